// File: rtl/regbank_mp.sv
// regbank_mp: parametrised register bank, two read ports, one write port.
//   Hardwired zero register (ZERO_REG), same-cycle write-to-read bypass,
//   per-port registered read-valid, and a multi-cycle clear sequencer.
//   Optional parity storage enabled by defining REGBANK_PARITY_EN.
// Ports:
//   clk, reset              clock (rising edge), async active-low reset
//   rd0_en/addr/data/valid  read port 0 (1-cycle latency)
//   rd1_en/addr/data/valid  read port 1 (1-cycle latency)
//   wr_en/addr/data         write port
//   clr_req, busy           start clear of all entries / clear in progress
//   wr_perr_inj             (REGBANK_PARITY_EN) invert stored parity on write
//   rd0_perr, rd1_perr      (REGBANK_PARITY_EN) stored parity mismatch
module regbank_mp #(
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned ADDR_W   = 5,
   parameter int unsigned ZERO_REG = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              rd0_en,
   input  logic [ADDR_W-1:0] rd0_addr,
   output logic [DATA_W-1:0] rd0_data,
   output logic              rd0_valid,
   input  logic              rd1_en,
   input  logic [ADDR_W-1:0] rd1_addr,
   output logic [DATA_W-1:0] rd1_data,
   output logic              rd1_valid,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
`ifdef REGBANK_PARITY_EN
   input  logic              wr_perr_inj,
   output logic              rd0_perr,
   output logic              rd1_perr,
`endif
   input  logic              clr_req,
   output logic              busy
);

   localparam int unsigned NUM_REGS = 2**ADDR_W;
   localparam bit          ZERO_EN  = (ZERO_REG != 0);

   typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic [DATA_W-1:0] mem [NUM_REGS];

   logic              mem_we_c;
   logic [ADDR_W-1:0] mem_waddr_c;
   logic [DATA_W-1:0] mem_wdata_c;
   logic              rd0_upd_c, rd1_upd_c;
   logic [DATA_W-1:0] rd0_sel_c, rd1_sel_c;

`ifdef REGBANK_PARITY_EN
   logic              mem_par [NUM_REGS];
   logic              mem_wpar_c;
   logic              rd0_psel_c, rd1_psel_c;
`endif

   // State and clear-counter registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         busy    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         busy    <= (state_d == CLEAR);
      end
   end

   // Next state, memory write port and read-update strobes
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      mem_we_c    = 1'b0;
      mem_waddr_c = wr_addr;
      mem_wdata_c = wr_data;
      rd0_upd_c   = 1'b0;
      rd1_upd_c   = 1'b0;
`ifdef REGBANK_PARITY_EN
      mem_wpar_c  = (^wr_data) ^ wr_perr_inj;
`endif
      case (state_q)
         IDLE: begin
            // Writes to the hardwired zero entry are dropped
            mem_we_c  = wr_en && !(ZERO_EN && (wr_addr == '0));
            rd0_upd_c = rd0_en;
            rd1_upd_c = rd1_en;
            if (clr_req) state_d = CLEAR;
         end
         CLEAR: begin
            mem_we_c    = 1'b1;
            mem_waddr_c = cnt_q;
            mem_wdata_c = '0;
`ifdef REGBANK_PARITY_EN
            mem_wpar_c  = 1'b0;
`endif
            // Counter wraps to 0 naturally after the last entry
            cnt_d = cnt_q + ADDR_W'(1);
            if (cnt_q == ADDR_W'(NUM_REGS - 1)) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Storage array; reset clears every entry
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int unsigned i = 0; i < NUM_REGS; i++) begin
            mem[i] <= '0;
`ifdef REGBANK_PARITY_EN
            mem_par[i] <= 1'b0;
`endif
         end
      end else if (mem_we_c) begin
         mem[mem_waddr_c] <= mem_wdata_c;
`ifdef REGBANK_PARITY_EN
         mem_par[mem_waddr_c] <= mem_wpar_c;
`endif
      end
   end

   // Port 0 data select: zero register, then bypass, then storage
   always_comb begin
      rd0_sel_c = mem[rd0_addr];
`ifdef REGBANK_PARITY_EN
      rd0_psel_c = (^mem[rd0_addr]) ^ mem_par[rd0_addr];
`endif
      if (ZERO_EN && (rd0_addr == '0)) begin
         rd0_sel_c = '0;
`ifdef REGBANK_PARITY_EN
         rd0_psel_c = 1'b0;
`endif
      end else if (wr_en && (wr_addr == rd0_addr)) begin
         rd0_sel_c = wr_data;
`ifdef REGBANK_PARITY_EN
         rd0_psel_c = 1'b0;
`endif
      end
   end

   // Port 1 data select: zero register, then bypass, then storage
   always_comb begin
      rd1_sel_c = mem[rd1_addr];
`ifdef REGBANK_PARITY_EN
      rd1_psel_c = (^mem[rd1_addr]) ^ mem_par[rd1_addr];
`endif
      if (ZERO_EN && (rd1_addr == '0)) begin
         rd1_sel_c = '0;
`ifdef REGBANK_PARITY_EN
         rd1_psel_c = 1'b0;
`endif
      end else if (wr_en && (wr_addr == rd1_addr)) begin
         rd1_sel_c = wr_data;
`ifdef REGBANK_PARITY_EN
         rd1_psel_c = 1'b0;
`endif
      end
   end

   // Read output registers; data holds when no read is accepted
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd0_valid <= 1'b0;
         rd0_data  <= '0;
         rd1_valid <= 1'b0;
         rd1_data  <= '0;
`ifdef REGBANK_PARITY_EN
         rd0_perr  <= 1'b0;
         rd1_perr  <= 1'b0;
`endif
      end else begin
         rd0_valid <= rd0_upd_c;
         rd1_valid <= rd1_upd_c;
         if (rd0_upd_c) begin
            rd0_data <= rd0_sel_c;
`ifdef REGBANK_PARITY_EN
            rd0_perr <= rd0_psel_c;
`endif
         end
         if (rd1_upd_c) begin
            rd1_data <= rd1_sel_c;
`ifdef REGBANK_PARITY_EN
            rd1_perr <= rd1_psel_c;
`endif
         end
      end
   end

endmodule

// File: doc/regbank_mp.md
Name: regbank_mp

Overview:
- Parametrised successor to the 32x32 register bank: configurable width and depth, two independent read ports and one write port.
- Adds hardwired zero register, write-to-read bypass, per-port read-valid handshake and a multi-cycle synchronous clear sequencer.
- Sits between decode (read addresses) and writeback (write port) in the RISC-V core datapath.

Parameters:
DATA_W, 32, bits per register
ADDR_W, 5, address width; NUM_REGS = 2**ADDR_W entries
ZERO_REG, 1, 1 = entry 0 reads 0 and ignores writes; 0 = entry 0 is an ordinary register

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  asynchronous, active-low reset
rd0_en  in  1  read request, port 0
rd0_addr  in  ADDR_W  read address, port 0
rd0_data  out  DATA_W  read data, port 0
rd0_valid  out  1  rd0_data valid this cycle
rd1_en  in  1  read request, port 1
rd1_addr  in  ADDR_W  read address, port 1
rd1_data  out  DATA_W  read data, port 1
rd1_valid  out  1  rd1_data valid this cycle
wr_en  in  1  write request
wr_addr  in  ADDR_W  write address
wr_data  in  DATA_W  write data
clr_req  in  1  start synchronous clear of all entries
busy  out  1  clear sequence in progress

Behaviour:
- Reset (reset=0, async): all entries 0; rd0_data=rd1_data=0; rd0_valid=rd1_valid=0; busy=0; state IDLE; clear counter 0.
- States: IDLE, CLEAR. busy = (state==CLEAR), registered.
- Write (IDLE only): wr_en=1 at edge → mem[wr_addr]<=wr_data. If ZERO_REG=1 and wr_addr=0, the write is dropped.
- Read (IDLE only): rdN_en=1 at edge T → rdN_valid=1 and rdN_data valid during cycle T+1 (1-cycle latency).
- rdN_en=0, or state CLEAR: rdN_valid=0 next cycle; rdN_data holds its last value.
- Read data selection, in priority order:
  - ZERO_REG=1 and addr=0 → 0.
  - wr_en=1 and wr_addr==rdN_addr in the same cycle → wr_data (bypass).
  - otherwise → mem[addr].
- Ports are independent; both may read the same address in the same cycle.
- Clear:
  - clr_req=1 in IDLE at edge T → CLEAR; busy=1 during cycles T+1..T+NUM_REGS.
  - Each CLEAR cycle writes 0 to mem[cnt], then cnt increments.
  - At cnt=NUM_REGS-1: write 0, cnt wraps to 0, return to IDLE; busy=0 at T+NUM_REGS+1.
- Same-cycle events in IDLE:
  - clr_req with wr_en/rdN_en in the same cycle: write and reads are performed, then CLEAR begins.
- During CLEAR: wr_en, rdN_en and clr_req are ignored (no queuing).
- Reset asserted mid-CLEAR: immediately IDLE, busy=0, all entries 0.

Optional Feature:
- Macro REGBANK_PARITY_EN.
- Defined:
  - Each entry stores an extra even-parity bit, computed from wr_data on write; clear and reset store parity 0.
  - Added outputs rd0_perr and rd1_perr (1 bit each). Each is valid with rdN_valid and asserts when the stored parity mismatches the stored data; forced 0 for bypass and zero-register reads; 0 on reset.
  - Added input wr_perr_inj (1 bit): when high with an accepted write, the stored parity bit is inverted (error injection).
- Undefined: no parity storage; none of the rd0_perr, rd1_perr or wr_perr_inj ports exist.

Test Plan:
- Reset, then write 0xDEADBEEF to addr 5; next cycle rd0_en/rd0_addr=5 → one cycle later rd0_valid=1, rd0_data=0xDEADBEEF.
- ZERO_REG=1: write 0x12345678 to addr 0; read addr 0 on both ports → 0. ZERO_REG=0: same sequence → 0x12345678.
- Same cycle: wr_en addr 7 data 0xA5A5A5A5, rd1_en addr 7 → next cycle rd1_data=0xA5A5A5A5, rd1_valid=1; rd0 at addr 8 unaffected.
- Fill all 32 entries, pulse clr_req → busy high exactly 32 cycles; writes/reads during busy are ignored (rd_valid=0); afterwards every entry reads 0.
- Assert reset low mid-write stream and mid-CLEAR, asynchronously between edges → busy, rd_valid and rd_data go 0 immediately; a subsequent read of any address → 0.
- REGBANK_PARITY_EN: write 0x1 to addr 3 with wr_perr_inj=1; read addr 3 → rd0_perr=1. Rewrite without injection → rd0_perr=0.
